// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle MIPS EX-stage ALU behind a start/done handshake.
//             Logic, arithmetic, shift and compare ops finish in one cycle;
//             MULTU (shift-add) and DIVU (restoring) iterate one bit per
//             cycle and report the wide result on hi/result.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       control_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  localparam logic [SW-1:0] CNT_MAX = SW'(WIDTH - 1);
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;       // multiplier bits / dividend->quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_ovf, is_multi;
  logic [WIDTH-1:0] add_sum, sub_diff;
  logic [SW-1:0]    shamt;

  logic [WIDTH:0]   mul_sum, div_shift, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] it_acc, it_sh;

  assign add_sum  = a_i + b_i;
  assign sub_diff = a_i - b_i;
  assign shamt    = a_i[SW-1:0];
  assign is_multi = (control_i == OP_MULTU) ||
                    ((control_i == OP_DIVU) && (b_i != '0));

  // Single-cycle result for the operation presented on the inputs
  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_ovf = 1'b0;
    case (control_i)
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_NOR:  alu_res = ~(a_i | b_i);
      OP_ADD: begin
        alu_res = add_sum;
        alu_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_diff;
        alu_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_SLL:  alu_res = b_i << shamt;
      OP_SRL:  alu_res = b_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(b_i) >>> shamt);
      OP_DIVU: begin
        // Only reached as a single-cycle op when the divisor is zero
        alu_res = '1;
        alu_hi  = a_i;
      end
      default: begin
        alu_res = '0;
        alu_hi  = '0;
      end
    endcase
  end

  // One iteration step of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_sub   = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (is_div_q) begin
      it_acc = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
      it_sh  = {sh_q[WIDTH-2:0], div_ge};
    end else begin
      it_acc = mul_sum[WIDTH:1];
      it_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Control FSM and datapath next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    hi_d     = hi_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_ITER: begin
        acc_d = it_acc;
        sh_d  = it_sh;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = it_sh;
          hi_d     = it_acc;
          ovf_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        if (start_i) begin
          if (is_multi) begin
            state_d  = S_ITER;
            cnt_d    = CNT_MAX;
            is_div_d = (control_i == OP_DIVU);
            acc_d    = '0;
            sh_d     = a_i;
            opnd_d   = b_i;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            hi_d     = alu_hi;
            ovf_d    = alu_ovf;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      hi_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready_o    = (state_q != S_ITER);
  assign done_o     = (state_q == S_DONE);
  assign result_o   = result_q;
  assign hi_o       = hi_q;
  assign zero_o     = (result_q == '0);
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the MIPS datapath that succeeds the single-cycle combinational ALU. It keeps the existing 4-bit control encoding and adds XOR, shifts, signed and unsigned compare, iterative unsigned multiply and divide (HI/LO outputs), and signed overflow detection. It sits in the EX stage behind a start/done handshake, so the pipeline control can stall on long operations.

## Interface
- WIDTH, 32, datapath width; power of two, 8..64; SW = log2(WIDTH)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- control  in  4  operation code, sampled on accept
- a, b  in  WIDTH each  operands, sampled on accept
- ready  out  1  block can accept start this cycle
- done  out  1  one-cycle pulse: result, hi, zero and overflow are valid
- result  out  WIDTH  primary result (LO for MULTU/DIVU)
- hi  out  WIDTH  MULTU high half / DIVU remainder; 0 for other ops
- zero  out  1  result == 0
- overflow  out  1  signed overflow; ADD/SUB only, else 0

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 0011 XOR, 0100 SLL (b << a[SW-1:0]), 0101 SRL, 1000 SRA (arith, b >>> a[SW-1:0]), 1001 SLTU, 1010 MULTU, 1011 DIVU. Any other code: result=0, hi=0, overflow=0; completes as a single-cycle op.
- SLT/SLTU: result = {WIDTH-1 zeros, flag}.
- ADD/SUB: result modulo 2^WIDTH; overflow = operand signs agree (ADD) or differ (SUB) and result sign differs from a.
- MULTU: shift-add, one multiplier bit per cycle; {hi,result} = a*b, 2*WIDTH bits, exact.
- DIVU: restoring division, one quotient bit per cycle; result = a/b, hi = a%b.
- DIVU with b=0: no iteration; result = all ones, hi = a; completes as a single-cycle op.
- FSM states: IDLE, ITER, DONE.
  - IDLE/DONE with start: single-cycle op → DONE; MULTU/DIVU (b≠0) → ITER with counter = WIDTH-1.
  - IDLE/DONE without start → IDLE.
  - ITER: counter decrements each cycle; leaves for DONE in the cycle counter = 0.
- ready = (state ≠ ITER). start while in ITER is ignored, not queued.
- Outputs are registered; they are updated only on entry to DONE and hold until the next DONE. Internal partial products are not visible on result/hi.
- zero is computed from the registered result.

## Timing
- Reset values: state IDLE, done 0, ready 1, result 0, hi 0, zero 1, overflow 0, counter 0.
- Single-cycle op accepted at edge N: done=1 during cycle N+1 with valid outputs.
- MULTU/DIVU accepted at edge N: ITER spans cycles N+1..N+WIDTH; done=1 during cycle N+WIDTH+1. Total latency is WIDTH+1 cycles.
- Back-to-back operation: start in the DONE cycle is accepted, giving a throughput of one single-cycle op per cycle.
- done is high for exactly one cycle per accepted op. It is never asserted without a prior accept.
- reset during ITER or DONE: next state is IDLE, all outputs return to their reset values, no done is produced, and the in-flight op is discarded.
- Operand or control changes after accept have no effect on the in-flight op.

## Test plan
- Reset then idle: hold reset 2 cycles → result=0, hi=0, zero=1, ready=1, done=0; start=0 for 5 cycles → done stays 0.
- Single-cycle ops, back-to-back, WIDTH=32: ADD 0x7FFFFFFF+1 → result=0x80000000, overflow=1; SUB 5-5 → 0, zero=1; SLT -1<1 → 1; SLTU 0xFFFFFFFF<1 → 0; SRA 0x80000000 by 4 → 0xF8000000. Each done exactly 1 cycle after its start.
- MULTU 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, result=0x00000001; done exactly 33 cycles after accept, ready=0 for 32 cycles; a start pulse mid-ITER is ignored.
- DIVU 100/7 → result=14, hi=2 after 33 cycles; DIVU 9/0 → result=0xFFFFFFFF, hi=9, done after 1 cycle.
- reset asserted at cycle 10 of a MULTU → IDLE and reset values next cycle, no done; a subsequent ADD 2+3 → result=5 after 1 cycle.
- WIDTH=8 build: MULTU 0xFF*0xFF → hi=0xFE, result=0x01 in 9 cycles; SLL 1 by a=0x0F (uses a[2:0]=7) → 0x80.
